// File: rtl/nios2_system_ledseq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, bit positions, FSM states.
package nios2_system_ledseq_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_PERIOD    = 3'd1;
  localparam logic [2:0] REG_STATUS    = 3'd2;
  localparam logic [2:0] REG_STEP_BASE = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_LAST_LO = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_STEP_LO = 1;
  localparam int STAT_DONE    = 3;
  localparam int STAT_TRIG    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/nios2_system_ledseq_tick.sv
// Loadable down-counter that times one sequencer step; zero flag marks the end of the step.
module nios2_system_ledseq_tick #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nios2_system_ledseq.sv
// LED pattern sequencer: Avalon-MM config slave plus write-only master to the LED PIO.
// Optional hardware start input enabled by defining LEDSEQ_HW_TRIGGER_EN.
module nios2_system_ledseq
  import nios2_system_ledseq_pkg::*;
#(
  parameter int                LED_W        = 5,
  parameter int                PERIOD_W     = 24,
  parameter logic [LED_W-1:0]  IDLE_PATTERN = 5'h1F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        busy
`ifdef LEDSEQ_HW_TRIGGER_EN
  ,
  input  logic        trig_in
`endif
);

  localparam logic [PERIOD_W-1:0] ONE = 1;

  state_e              state, state_next;
  logic                en, oneshot, done;
  logic [1:0]          last, step, step_next;
  logic [PERIOD_W-1:0] period, reload;
  logic [LED_W-1:0]    step_tbl [4];
  logic                cnt_load, cnt_en, cnt_zero, seq_done;
  logic                trig_level, trig_start;
  logic                wr;
  logic                unused_wdata;

  assign wr           = s_chipselect && !s_write_n;
  assign reload       = (period == '0) ? '0 : period - ONE;
  assign unused_wdata = ^s_writedata[31:PERIOD_W];

`ifdef LEDSEQ_HW_TRIGGER_EN
  logic [2:0] trig_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trig_sr <= '0;
    else          trig_sr <= {trig_sr[1:0], trig_in};
  end

  assign trig_level = trig_sr[1];
  assign trig_start = trig_sr[1] && !trig_sr[2] && (state == ST_IDLE);
`else
  assign trig_level = 1'b0;
  assign trig_start = 1'b0;
`endif

  // NOTE: the step table is only four small registers, so it is reset like any other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      last    <= '0;
      period  <= '0;
      done    <= 1'b0;
      for (int i = 0; i < 4; i++) step_tbl[i] <= '0;
    end else begin
      if (wr) begin
        if (s_address == REG_CTRL) begin
          en      <= s_writedata[CTRL_EN];
          oneshot <= s_writedata[CTRL_ONESHOT];
          last    <= s_writedata[CTRL_LAST_LO +: 2];
        end else if (s_address == REG_PERIOD) begin
          period <= s_writedata[PERIOD_W-1:0];
        end else if (s_address == REG_STATUS) begin
          if (s_writedata[STAT_DONE]) done <= 1'b0;
        end else if (s_address[2]) begin
          step_tbl[s_address[1:0]] <= s_writedata[LED_W-1:0];
        end
      end
      // Sequencer events take priority over a same-cycle CPU write.
      if (seq_done) begin
        done <= 1'b1;
        en   <= 1'b0;
      end
      if (trig_start) begin
        en      <= 1'b1;
        oneshot <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    step_next    = step;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    seq_done     = 1'b0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    unique case (state)
      ST_IDLE: begin
        if (en) begin
          step_next  = '0;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        m_chipselect               = 1'b1;
        m_write_n                  = 1'b0;
        m_writedata[LED_W-1:0]     = step_tbl[step];
        cnt_load                   = 1'b1;
        state_next                 = ST_WAIT;
      end
      ST_WAIT: begin
        if (!en) begin
          state_next = ST_STOP;
        end else if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (step < last) begin
          step_next  = step + 2'd1;
          state_next = ST_WRITE;
        end else if (!oneshot) begin
          step_next  = '0;
          state_next = ST_WRITE;
        end else begin
          seq_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_STOP: begin
        m_chipselect           = 1'b1;
        m_write_n              = 1'b0;
        m_writedata[LED_W-1:0] = IDLE_PATTERN;
        state_next             = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  nios2_system_ledseq_tick #(.W(PERIOD_W)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (reload),
    .zero     (cnt_zero)
  );

  assign busy      = (state != ST_IDLE);
  assign m_address = 2'b00;

  always_comb begin
    s_readdata = '0;
    if (s_address == REG_CTRL) begin
      s_readdata[CTRL_EN]           = en;
      s_readdata[CTRL_ONESHOT]      = oneshot;
      s_readdata[CTRL_LAST_LO +: 2] = last;
    end else if (s_address == REG_PERIOD) begin
      s_readdata[PERIOD_W-1:0] = period;
    end else if (s_address == REG_STATUS) begin
      s_readdata[STAT_BUSY]         = busy;
      s_readdata[STAT_STEP_LO +: 2] = step;
      s_readdata[STAT_DONE]         = done;
      s_readdata[STAT_TRIG]         = trig_level;
    end else if (s_address[2]) begin
      s_readdata[LED_W-1:0] = step_tbl[s_address[1:0]];
    end
  end

endmodule

// File: tb/tb_nios2_system_ledseq.sv
// Self-checking bench for nios2_system_ledseq: expected strobe values and spacing come from the table rules.
module tb_nios2_system_ledseq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        busy;
`ifdef LEDSEQ_HW_TRIGGER_EN
  logic        trig_in = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] wr_q [$];
  int          cyc_q [$];
  logic [1:0]  stp_q [$];

  nios2_system_ledseq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .busy         (busy)
`ifdef LEDSEQ_HW_TRIGGER_EN
    ,
    .trig_in      (trig_in)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Log every master write strobe with its cycle and the STATUS step field.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && m_chipselect === 1'b1 && m_write_n === 1'b0) begin
      wr_q.push_back(m_writedata);
      cyc_q.push_back(cyc);
      stp_q.push_back(s_readdata[2:1]);
      check("m_address", {30'd0, m_address}, 32'd0);
    end
  end

  task automatic clear_q();
    wr_q.delete();
    cyc_q.delete();
    stp_q.delete();
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write_n = 1'b1; s_address = 3'd2;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    s_address = a;
    #1 d = s_readdata;
    s_address = 3'd2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (wr_q.size() >= n) break;
    end
    check(tag, 32'(wr_q.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] q_at(input int k);
    return (k < wr_q.size()) ? wr_q[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic int gap_at(input int k);
    return (k < cyc_q.size() && k > 0) ? cyc_q[k] - cyc_q[k-1] : -1;
  endfunction

  logic [31:0] rd;
  logic [4:0]  tbl [4];
  int          p, last, n, exp_gap;

  initial begin
    reset_n = 1'b0; s_address = 3'd2; s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
    check("rst_m_wn", {31'd0, m_write_n}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_wd", m_writedata, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      cpu_read(3'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, 32'd0);
    end

    // Continuous sequencing: first trial is the 1,2,4,8 table, the rest are random.
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        tbl[0] = 5'd1; tbl[1] = 5'd2; tbl[2] = 5'd4; tbl[3] = 5'd8; p = 3; last = 3;
      end else begin
        for (int i = 0; i < 4; i++) tbl[i] = 5'($urandom_range(0, 31));
        p = $urandom_range(0, 6); last = $urandom_range(0, 3);
      end
      for (int i = 0; i < 4; i++) cpu_write(3'(4 + i), {27'd0, tbl[i]});
      cpu_write(3'd1, 32'(p));
      clear_q();
      cpu_write(3'd0, 32'((last << 2) | 1));
      n = 2 * (last + 1) + 1;
      exp_gap = ((p == 0) ? 1 : p) + 1;
      wait_strobes($sformatf("t%0d_count", t), n, n * (p + 3) + 40);
      for (int k = 0; k < n; k++) begin
        check($sformatf("t%0d_val%0d", t, k), q_at(k), {27'd0, tbl[k % (last + 1)]});
        check($sformatf("t%0d_step%0d", t, k),
              (k < stp_q.size()) ? {30'd0, stp_q[k]} : 32'hDEAD, 32'(k % (last + 1)));
        if (k > 0) check($sformatf("t%0d_gap%0d", t, k), 32'(gap_at(k)), 32'(exp_gap));
      end
      check($sformatf("t%0d_busy", t), {31'd0, busy}, 32'd1);
      cpu_write(3'd0, 32'd0);
      idle(20);
      check($sformatf("t%0d_stopped", t), {31'd0, busy}, 32'd0);
    end

    // One-shot run of 1,2,4,8 then DONE handling.
    tbl[0] = 5'd1; tbl[1] = 5'd2; tbl[2] = 5'd4; tbl[3] = 5'd8;
    for (int i = 0; i < 4; i++) cpu_write(3'(4 + i), {27'd0, tbl[i]});
    cpu_write(3'd1, 32'd3);
    clear_q();
    cpu_write(3'd0, 32'hF);
    wait_strobes("os_count", 4, 80);
    idle(15);
    check("os_total", 32'(wr_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("os_val%0d", k), q_at(k), {27'd0, tbl[k]});
      if (k > 0) check($sformatf("os_gap%0d", k), 32'(gap_at(k)), 32'd4);
    end
    check("os_busy", {31'd0, busy}, 32'd0);
    cpu_read(3'd2, rd);
    check("os_done", {31'd0, rd[3]}, 32'd1);
    check("os_stat_busy", {31'd0, rd[0]}, 32'd0);
    cpu_read(3'd0, rd);
    check("os_en_clr", {31'd0, rd[0]}, 32'd0);
    cpu_write(3'd2, 32'h8);
    cpu_read(3'd2, rd);
    check("os_done_clr", {31'd0, rd[3]}, 32'd0);

    // Clear EN during WAIT: exactly one idle-pattern write follows.
    for (int i = 0; i < 4; i++) cpu_write(3'(4 + i), 32'($urandom_range(0, 30)));
    cpu_write(3'd1, 32'd4);
    clear_q();
    cpu_write(3'd0, 32'h1);
    wait_strobes("stop_first", 1, 40);
    cpu_write(3'd0, 32'h0);
    idle(20);
    check("stop_total", 32'(wr_q.size()), 32'd2);
    check("stop_pattern", q_at(1), 32'h1F);
    check("stop_busy", {31'd0, busy}, 32'd0);

    // PERIOD=0, single step; STEP0 rewritten mid-run shows on the following strobe.
    cpu_write(3'd4, 32'h15);
    cpu_write(3'd1, 32'd0);
    clear_q();
    cpu_write(3'd0, 32'h1);
    wait_strobes("p0_count", 3, 30);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("p0_val%0d", k), q_at(k), 32'h15);
      if (k > 0) check($sformatf("p0_gap%0d", k), 32'(gap_at(k)), 32'd2);
    end
    cpu_write(3'd4, 32'h0A);
    n = wr_q.size();
    wait_strobes("p0_upd_count", n + 2, 30);
    check("p0_before_upd", q_at(n - 1), 32'h15);
    check("p0_upd0", q_at(n), 32'h0A);
    check("p0_upd1", q_at(n + 1), 32'h0A);
    check("p0_upd_gap", 32'(gap_at(n)), 32'd2);
    cpu_write(3'd0, 32'h0);
    idle(10);
    check("p0_stopped", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of WAIT.
    cpu_write(3'd1, 32'd4);
    clear_q();
    cpu_write(3'd0, 32'h1);
    wait_strobes("rst_run", 1, 40);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_m_cs", {31'd0, m_chipselect}, 32'd0);
    check("arst_m_wn", {31'd0, m_write_n}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_m_wd", m_writedata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_q();
    idle(30);
    check("arst_no_writes", 32'(wr_q.size()), 32'd0);
    cpu_read(3'd0, rd);
    check("arst_ctrl", rd, 32'd0);
    cpu_read(3'd2, rd);
    check("arst_status", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
